stopwatch_ctrl: RTL and testbench

Control sequencer for the stopwatch counter/display datapath. It conditions the three raw push-buttons (start/stop, reset, lap) with synchronisation, debounce and edge detection, then runs a run/pause/lap state machine. From that state it emits the count-enable tick, counter clear, lap-capture pulse and display-hold level that drive the stopwatch counter and 7-segment display path.

---
 rtl/stopwatch_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer.
// Conditions the start/stop, reset and lap push-buttons (synchronise,
// debounce, rising-edge detect), then runs the IDLE/RUN/PAUSE/LAP state
// machine. The machine drives the counter tick, counter clear, lap capture
// and display-hold controls of the stopwatch datapath.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop_btn,
  input  logic       reset_btn,
  input  logic       lap_btn,
  output logic       tick_en,
  output logic       count_clr,
  output logic       lap_latch,
  output logic       display_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_e;

  localparam int NUM_BTN = 3;
  localparam int BTN_SS  = 0;
  localparam int BTN_RST = 1;
  localparam int BTN_LAP = 2;

  // The debounce counter only ever holds 0..DEBOUNCE_CYCLES-1.
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PS_W = $clog2(TICK_DIV);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  // ---------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------
  logic [NUM_BTN-1:0]            btn_raw;
  logic [NUM_BTN-1:0]            sync1_q;
  logic [NUM_BTN-1:0]            sync2_q;
  logic [NUM_BTN-1:0]            db_q;
  logic [NUM_BTN-1:0]            db_d;
  logic [NUM_BTN-1:0]            db_prev_q;
  logic [NUM_BTN-1:0][DB_W-1:0]  db_cnt_q;
  logic [NUM_BTN-1:0][DB_W-1:0]  db_cnt_d;
  logic [NUM_BTN-1:0]            press;

  assign btn_raw = {lap_btn, reset_btn, start_stop_btn};

  // A debounced level flips only after DEBOUNCE_CYCLES consecutive
  // disagreeing synchronised samples; any agreeing sample restarts the count.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      // NOTE: every always_comb output gets a default before any branch so
      // no path leaves it unassigned, which would infer a latch.
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Synchroniser chain, debounce state and previous debounced level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: synchroniser and debounce flops are reset too, so a reset
      // mid-bounce cannot leave a half-counted press behind.
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      db_cnt_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others (the sync chain relies on it).
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      db_cnt_q  <= db_cnt_d;
    end
  end

  // Rising edge of the debounced level; releases produce nothing.
  assign press = db_q & ~db_prev_q;

  // ---------------------------------------------------------------------
  // Run/pause/lap state machine and tick prescaler
  // ---------------------------------------------------------------------
  state_e            state_q;
  state_e            state_d;
  logic [PS_W-1:0]   presc_q;
  logic [PS_W-1:0]   presc_d;
  logic              count_clr_q;
  logic              count_clr_d;
  logic              lap_latch_q;
  logic              lap_latch_d;
  logic              tick_en_q;
  logic              tick_en_d;
  logic              display_hold_q;
  logic              display_hold_d;
  logic              counting;

  // Next state from the single highest-priority press, plus the prescaler
  // and the registered output values that go with the new state.
  always_comb begin
    state_d     = state_q;
    count_clr_d = 1'b0;
    lap_latch_d = 1'b0;

    if (press[BTN_RST]) begin
      case (state_q)
        ST_IDLE:  count_clr_d = 1'b1;
        ST_PAUSE: begin
          state_d     = ST_IDLE;
          count_clr_d = 1'b1;
        end
        ST_LAP:   state_d = ST_RUN;
        default:  ;
      endcase
    end else if (press[BTN_SS]) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_LAP:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  ;
      endcase
    end else if (press[BTN_LAP]) begin
      case (state_q)
        ST_RUN: begin
          state_d     = ST_LAP;
          lap_latch_d = 1'b1;
        end
        ST_LAP:  lap_latch_d = 1'b1;
        default: ;
      endcase
    end

    // The prescaler advances on edges spent in RUN/LAP, freezes in PAUSE so
    // a resume keeps the partial tick, and is zero in IDLE or on a clear.
    counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    presc_d  = presc_q;
    if ((state_q == ST_IDLE) || count_clr_d) begin
      presc_d = '0;
    end else if (counting) begin
      presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
    end

    tick_en_d      = ((state_d == ST_RUN) || (state_d == ST_LAP)) && (presc_d == PS_LAST);
    display_hold_d = (state_d == ST_LAP);
  end

  // State, prescaler and all outputs registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      presc_q        <= '0;
      count_clr_q    <= 1'b0;
      lap_latch_q    <= 1'b0;
      tick_en_q      <= 1'b0;
      display_hold_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      count_clr_q    <= count_clr_d;
      lap_latch_q    <= lap_latch_d;
      tick_en_q      <= tick_en_d;
      display_hold_q <= display_hold_d;
    end
  end

  assign state        = state_q;
  assign tick_en      = tick_en_q;
  assign count_clr    = count_clr_q;
  assign lap_latch    = lap_latch_q;
  assign display_hold = display_hold_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic,
// all compared against a cycle-level behavioural model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int D  = 4;
  localparam int TD = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  localparam logic [2:0] B_SS  = 3'b001;
  localparam logic [2:0] B_RST = 3'b010;
  localparam logic [2:0] B_LAP = 3'b100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_stop_btn = 1'b0;
  logic       reset_btn = 1'b0;
  logic       lap_btn = 1'b0;
  logic       tick_en;
  logic       count_clr;
  logic       lap_latch;
  logic       display_hold;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_stop_btn(start_stop_btn),
    .reset_btn(reset_btn),
    .lap_btn(lap_btn),
    .tick_en(tick_en),
    .count_clr(count_clr),
    .lap_latch(lap_latch),
    .display_hold(display_hold),
    .state(state)
  );

  // -------------------------------------------------------------------
  // Behavioural model
  // A button level is accepted once the last D synchronised samples (raw
  // samples taken two edges earlier) all disagree with the current level.
  // Ticks come from the number of counting edges since the last clear.
  // -------------------------------------------------------------------
  bit [D+1:0] m_hist [3];
  bit         m_db [3];
  bit         m_press [3];
  int         m_state;
  int         m_prev;
  int         m_elapsed;
  bit         m_tick, m_clr, m_lap, m_hold;
  logic [2:0] m_raw;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 3; b++) begin
        m_hist[b]  = '0;
        m_db[b]    = 1'b0;
        m_press[b] = 1'b0;
      end
      m_state = M_IDLE; m_elapsed = 0;
      m_tick = 0; m_clr = 0; m_lap = 0; m_hold = 0;
    end else begin
      m_raw  = {lap_btn, reset_btn, start_stop_btn};
      m_prev = m_state;
      m_clr  = 0;
      m_lap  = 0;
      if (m_press[1]) begin
        if (m_state == M_IDLE) m_clr = 1;
        else if (m_state == M_PAUSE) begin m_state = M_IDLE; m_clr = 1; end
        else if (m_state == M_LAP) m_state = M_RUN;
      end else if (m_press[0]) begin
        if (m_state == M_IDLE || m_state == M_PAUSE) m_state = M_RUN;
        else m_state = M_PAUSE;
      end else if (m_press[2]) begin
        if (m_state == M_RUN || m_state == M_LAP) begin m_state = M_LAP; m_lap = 1; end
      end
      if (m_prev == M_IDLE || m_clr) m_elapsed = 0;
      else if (m_prev == M_RUN || m_prev == M_LAP) m_elapsed++;
      m_tick = (m_state == M_RUN || m_state == M_LAP) && (m_elapsed % TD == TD - 1);
      m_hold = (m_state == M_LAP);
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = {m_hist[b][D:0], m_raw[b]};
        if (m_hist[b][D+1:2] == {D{~m_db[b]}}) begin
          m_db[b]    = ~m_db[b];
          m_press[b] = m_db[b];
        end else begin
          m_press[b] = 1'b0;
        end
      end
    end
  end

  function automatic logic [5:0] dut_vec();
    return {state, tick_en, count_clr, lap_latch, display_hold};
  endfunction

  function automatic logic [5:0] mdl_vec();
    return {m_state[1:0], m_tick, m_clr, m_lap, m_hold};
  endfunction

  // -------------------------------------------------------------------
  // Stimulus: hold a button pattern for 'hold' cycles inside a window of
  // 'len' cycles and report what the DUT did during the window.
  // -------------------------------------------------------------------
  typedef struct {
    int         mism;
    int         bad_k;
    logic [5:0] bad_dut;
    logic [5:0] bad_mdl;
    int         clr;
    int         lap;
    int         ticks;
    int         chg_k;
    int         tick_k;
    int         gap_min;
    int         gap_max;
    logic [1:0] st_end;
    logic       hold_end;
  } obs_t;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_btns(input logic [2:0] b);
    {lap_btn, reset_btn, start_stop_btn} = b;
  endtask

  task automatic drive(input logic [2:0] btns, input int hold, input int len, output obs_t o);
    logic [1:0] st0;
    int         last_tick;
    o = '{mism: 0, bad_k: -1, bad_dut: '0, bad_mdl: '0, clr: 0, lap: 0, ticks: 0,
          chg_k: -1, tick_k: -1, gap_min: 1000000, gap_max: 0, st_end: '0, hold_end: 1'b0};
    st0       = state;
    last_tick = -1;
    for (int k = 0; k < len; k++) begin
      set_btns((k < hold) ? btns : 3'b000);
      step();
      if (dut_vec() !== mdl_vec()) begin
        if (o.mism == 0) begin
          o.bad_k = k; o.bad_dut = dut_vec(); o.bad_mdl = mdl_vec();
        end
        o.mism++;
      end
      if (count_clr === 1'b1) o.clr++;
      if (lap_latch === 1'b1) o.lap++;
      if (o.chg_k < 0 && state !== st0) o.chg_k = k;
      if (tick_en === 1'b1) begin
        o.ticks++;
        if (o.tick_k < 0) o.tick_k = k;
        if (last_tick >= 0) begin
          if (k - last_tick < o.gap_min) o.gap_min = k - last_tick;
          if (k - last_tick > o.gap_max) o.gap_max = k - last_tick;
        end
        last_tick = k;
      end
    end
    o.st_end   = state;
    o.hold_end = display_hold;
  endtask

  // -------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------
  task automatic test_reset();
    obs_t o;
    reset_n = 1'b0;
    set_btns(3'b000);
    repeat (3) step();
    n_checks++;
    if (dut_vec() !== 6'b0) begin n_fail++; $display("FAIL reset_asserted: got %b expected %b", dut_vec(), 6'b0); end
    reset_n = 1'b1;
    drive(3'b000, 0, 6, o);
    n_checks++;
    if (o.mism !== 0) begin n_fail++; $display("FAIL reset_model: cycle %0d dut %b model %b", o.bad_k, o.bad_dut, o.bad_mdl); end
    n_checks++;
    if (dut_vec() !== 6'b0) begin n_fail++; $display("FAIL reset_released: got %b expected %b", dut_vec(), 6'b0); end
  endtask

  task automatic test_start_tick();
    obs_t o;
    drive(B_SS, 10, 40, o);
    n_checks++;
    if (o.mism !== 0) begin n_fail++; $display("FAIL start_model: cycle %0d dut %b model %b", o.bad_k, o.bad_dut, o.bad_mdl); end
    n_checks++;
    if (o.chg_k !== D + 2) begin n_fail++; $display("FAIL start_latency: got edge %0d expected %0d", o.chg_k, D + 2); end
    n_checks++;
    if (o.st_end !== 2'b01) begin n_fail++; $display("FAIL start_state: got %b expected %b", o.st_end, 2'b01); end
    n_checks++;
    if (o.tick_k - o.chg_k + 1 !== TD) begin n_fail++; $display("FAIL first_tick: got %0d cycles expected %0d", o.tick_k - o.chg_k + 1, TD); end
    n_checks++;
    if (o.gap_min !== TD || o.gap_max !== TD) begin n_fail++; $display("FAIL tick_period: got %0d..%0d expected %0d", o.gap_min, o.gap_max, TD); end
    n_checks++;
    if (o.ticks !== 6) begin n_fail++; $display("FAIL tick_count: got %0d expected %0d", o.ticks, 6); end
  endtask

  task automatic test_bounce();
    obs_t o1, o2;
    drive(B_SS, 3, 4, o1);
    drive(B_SS, 3, 16, o2);
    n_checks++;
    if (o1.mism + o2.mism !== 0) begin n_fail++; $display("FAIL bounce_model: got %0d mismatching cycles expected 0", o1.mism + o2.mism); end
    n_checks++;
    if (o1.chg_k !== -1 || o2.chg_k !== -1 || o2.st_end !== 2'b01) begin
      n_fail++; $display("FAIL bounce_state: got change %0d/%0d state %b expected none, 01", o1.chg_k, o2.chg_k, o2.st_end);
    end
    n_checks++;
    if (o1.clr + o1.lap + o2.clr + o2.lap !== 0) begin n_fail++; $display("FAIL bounce_strobes: got %0d expected 0", o1.clr + o1.lap + o2.clr + o2.lap); end
  endtask

  task automatic test_reset_ignored_in_run();
    obs_t o;
    drive(B_RST, 4, 16, o);
    n_checks++;
    if (o.mism !== 0) begin n_fail++; $display("FAIL run_reset_model: cycle %0d dut %b model %b", o.bad_k, o.bad_dut, o.bad_mdl); end
    n_checks++;
    if (o.chg_k !== -1 || o.clr !== 0) begin n_fail++; $display("FAIL run_reset_ignored: got change %0d clr %0d expected -1, 0", o.chg_k, o.clr); end
  endtask

  task automatic test_same_cycle_priority();
    obs_t o;
    drive(B_RST | B_LAP, 4, 16, o);
    n_checks++;
    if (o.mism !== 0) begin n_fail++; $display("FAIL priority_model: cycle %0d dut %b model %b", o.bad_k, o.bad_dut, o.bad_mdl); end
    n_checks++;
    if (o.chg_k !== -1 || o.lap !== 0 || o.clr !== 0) begin
      n_fail++; $display("FAIL priority_discard: got change %0d lap %0d clr %0d expected -1, 0, 0", o.chg_k, o.lap, o.clr);
    end
  endtask

  task automatic test_lap();
    obs_t o;
    drive(B_LAP, 4, 20, o);
    n_checks++;
    if (o.mism !== 0) begin n_fail++; $display("FAIL lap1_model: cycle %0d dut %b model %b", o.bad_k, o.bad_dut, o.bad_mdl); end
    n_checks++;
    if (o.st_end !== 2'b11 || o.hold_end !== 1'b1 || o.lap !== 1) begin
      n_fail++; $display("FAIL lap1: got state %b hold %b laps %0d expected 11, 1, 1", o.st_end, o.hold_end, o.lap);
    end
    n_checks++;
    if (o.ticks < 2) begin n_fail++; $display("FAIL lap_ticks: got %0d expected at least 2", o.ticks); end
    drive(B_LAP, 4, 14, o);
    n_checks++;
    if (o.mism !== 0) begin n_fail++; $display("FAIL lap2_model: cycle %0d dut %b model %b", o.bad_k, o.bad_dut, o.bad_mdl); end
    n_checks++;
    if (o.st_end !== 2'b11 || o.lap !== 1) begin n_fail++; $display("FAIL lap2: got state %b laps %0d expected 11, 1", o.st_end, o.lap); end
    drive(B_RST, 4, 14, o);
    n_checks++;
    if (o.mism !== 0) begin n_fail++; $display("FAIL lap_exit_model: cycle %0d dut %b model %b", o.bad_k, o.bad_dut, o.bad_mdl); end
    n_checks++;
    if (o.st_end !== 2'b01 || o.hold_end !== 1'b0 || o.clr !== 0 || o.chg_k !== D + 2) begin
      n_fail++; $display("FAIL lap_exit: got state %b hold %b clr %0d edge %0d expected 01, 0, 0, %0d", o.st_end, o.hold_end, o.clr, o.chg_k, D + 2);
    end
  endtask

  task automatic test_pause_clear();
    obs_t o;
    drive(B_SS, 4, 14, o);
    n_checks++;
    if (o.mism !== 0 || o.st_end !== 2'b10) begin
      n_fail++; $display("FAIL pause_enter: got state %b mismatches %0d expected 10, 0", o.st_end, o.mism);
    end
    drive(B_RST, 4, 14, o);
    n_checks++;
    if (o.mism !== 0) begin n_fail++; $display("FAIL pause_clear_model: cycle %0d dut %b model %b", o.bad_k, o.bad_dut, o.bad_mdl); end
    n_checks++;
    if (o.st_end !== 2'b00 || o.clr !== 1 || o.chg_k !== D + 2) begin
      n_fail++; $display("FAIL pause_clear: got state %b clr %0d edge %0d expected 00, 1, %0d", o.st_end, o.clr, o.chg_k, D + 2);
    end
  endtask

  task automatic test_pause_resume();
    obs_t o;
    // Entry from IDLE: prescaler starts at zero after the clear.
    drive(B_SS, 4, 12, o);
    n_checks++;
    if (o.mism !== 0 || o.tick_k - o.chg_k + 1 !== TD) begin
      n_fail++; $display("FAIL restart_tick: got %0d cycles mismatches %0d expected %0d, 0", o.tick_k - o.chg_k + 1, o.mism, TD);
    end
    // Pause after 12 RUN cycles, leaving the prescaler at 2.
    drive(B_SS, 4, 30, o);
    n_checks++;
    if (o.mism !== 0 || o.st_end !== 2'b10) begin
      n_fail++; $display("FAIL resume_pause: got state %b mismatches %0d expected 10, 0", o.st_end, o.mism);
    end
    drive(3'b000, 0, 20, o);
    n_checks++;
    if (o.ticks !== 0 || o.mism !== 0) begin n_fail++; $display("FAIL pause_no_tick: got %0d ticks expected 0", o.ticks); end
    drive(B_SS, 4, 12, o);
    n_checks++;
    if (o.mism !== 0) begin n_fail++; $display("FAIL resume_model: cycle %0d dut %b model %b", o.bad_k, o.bad_dut, o.bad_mdl); end
    n_checks++;
    if (o.chg_k !== D + 2 || o.tick_k - o.chg_k + 1 !== 3) begin
      n_fail++; $display("FAIL resume_tick: got %0d cycles expected 3", o.tick_k - o.chg_k + 1);
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    set_btns(3'b000);
    step();
    set_btns(B_SS);
    repeat (3) step();
    #2;
    reset_n = 1'b0;
    set_btns(3'b000);
    #1;
    n_checks++;
    if (dut_vec() !== 6'b0) begin n_fail++; $display("FAIL async_reset: got %b expected %b", dut_vec(), 6'b0); end
    repeat (2) step();
    reset_n = 1'b1;
    drive(3'b000, 0, 16, o);
    n_checks++;
    if (o.mism !== 0 || o.chg_k !== -1 || o.st_end !== 2'b00) begin
      n_fail++; $display("FAIL async_abort: got state %b change %0d mismatches %0d expected 00, -1, 0", o.st_end, o.chg_k, o.mism);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0] b;
    int hold;
    for (int it = 0; it < 150; it++) begin
      b    = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 8);
      drive(b, hold, hold + $urandom_range(0, 12), o);
      n_checks++;
      if (o.mism !== 0) begin
        n_fail++; $display("FAIL random_%0d: cycle %0d dut %b model %b", it, o.bad_k, o.bad_dut, o.bad_mdl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_tick();
    test_bounce();
    test_reset_ignored_in_run();
    test_same_cycle_priority();
    test_lap();
    test_pause_clear();
    test_pause_resume();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule
